// File: rtl/quad_pkg.sv
// quad_pkg: shared constants for the quadrature step generator and decoder side.
// Holds the 2-bit A/B Gray codes, the FSM state encoding and the default
// position limit, plus the one-transition Gray advance helper.
package quad_pkg;

  // A/B channel codes, written as {A, B}
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;

  // Default highest position value; the decoder wraps at the same limit
  localparam logic [7:0] QUAD_MAX_DEFAULT = 8'd120;

  // Index of the last quadrature phase in one step (4 transitions per step)
  localparam logic [1:0] PHASE_LAST = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Advance one Gray transition.
  // CW : 00 -> 10 -> 11 -> 01 -> 00 (A leads B)
  // CCW: 00 -> 01 -> 11 -> 10 -> 00 (B leads A)
  function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic dir_cw);
    logic [1:0] nxt;
    nxt = AB_00;
    if (dir_cw) begin
      case (ab)
        AB_00:   nxt = AB_10;
        AB_10:   nxt = AB_11;
        AB_11:   nxt = AB_01;
        default: nxt = AB_00;
      endcase
    end else begin
      case (ab)
        AB_00:   nxt = AB_01;
        AB_01:   nxt = AB_11;
        AB_11:   nxt = AB_10;
        default: nxt = AB_00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/quad_dwell_timer.sv
// quad_dwell_timer: loadable down-counter that paces each quadrature phase.
// Ports: clk/rst; i_load + i_load_val set both the count and the reload value;
//        i_en decrements; o_expire is high while the count equals 1.
// On an enabled cycle at count 1 the counter reloads the latched value, so a
// phase of N clocks repeats without the parent re-loading it.
module quad_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_count;
  logic [W-1:0] r_reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_reload <= i_load_val;
    end else if (i_en) begin
      // Reload on 1 (expiry); also recovers from an unloaded 0 count
      if (r_count > W'(1)) begin
        r_count <= r_count - W'(1);
      end else begin
        r_count <= r_reload;
      end
    end
  end

  assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/quad_step_gen.sv
// quad_step_gen: quadrature transmitter turning step commands into A/B
// waveforms like a rotary encoder, with its own wrapped position counter.
// Ports: clk, rst (async active-high); step_valid/step_dir/dwell in,
//        step_ready out (valid/ready handshake, accepted only in IDLE);
//        A, B (registered quadrature), pos (wrapped 0..MAX), busy.
// Optional: define QUAD_STEP_GEN_INDEX_EN to add the idx output, a one-clock
//        pulse in the cycle after a step that wraps pos (index mark).
// Timing: first A/B change dwell_eff edges after accept; 4*dwell_eff clocks
//        per step; one IDLE cycle between back-to-back steps.
module quad_step_gen
  import quad_pkg::*;
#(
  parameter int               DWELL_W = 16,
  parameter int               POS_W   = 8,
  parameter logic [POS_W-1:0] MAX     = POS_W'(QUAD_MAX_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic               step_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic [POS_W-1:0]   pos,
  output logic               busy
`ifdef QUAD_STEP_GEN_INDEX_EN
  ,
  output logic               idx
`endif
);

  state_t             r_state;
  logic               r_dir;
  logic [1:0]         r_phase;
  logic [1:0]         r_ab;
  logic [POS_W-1:0]   r_pos;
  logic               r_busy;
  logic               r_ready;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic               w_accept;
  logic               w_expire;
  logic               w_run;
  logic [1:0]         w_ab_next;
  logic [POS_W-1:0]   w_pos_next;

  // A zero dwell would never expire; treat it as a single clock per phase
  assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_accept    = (r_state == ST_IDLE) && step_valid;
  assign w_run       = (r_state == ST_RUN);
  assign w_ab_next   = gray_next(r_ab, r_dir);

  // Wrapped position after the step in the latched direction
  always_comb begin
    w_pos_next = r_pos;
    if (r_dir) begin
      w_pos_next = (r_pos == MAX) ? '0 : (r_pos + POS_W'(1));
    end else begin
      w_pos_next = (r_pos == '0) ? MAX : (r_pos - POS_W'(1));
    end
  end

  // Timer is loaded on the accept edge and free-runs (self-reloading) in RUN
  quad_dwell_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (w_dwell_eff),
    .i_en       (w_run),
    .o_expire   (w_expire)
  );

`ifdef QUAD_STEP_GEN_INDEX_EN
  logic r_idx;
  logic w_wrap;
  // Wrap happens exactly when the stepped position crosses the MAX/0 seam
  assign w_wrap = r_dir ? (r_pos == MAX) : (r_pos == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_phase <= 2'd0;
      r_ab    <= AB_00;
      r_pos   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
`ifdef QUAD_STEP_GEN_INDEX_EN
      r_idx   <= 1'b0;
`endif
    end else begin
`ifdef QUAD_STEP_GEN_INDEX_EN
      r_idx <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (step_valid) begin
            r_dir   <= step_dir;
            r_phase <= 2'd0;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_expire) begin
            r_ab <= w_ab_next;
            if (r_phase == PHASE_LAST) begin
              // Fourth transition returns AB to 00 and completes the step
              r_pos   <= w_pos_next;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
`ifdef QUAD_STEP_GEN_INDEX_EN
              r_idx   <= w_wrap;
`endif
            end else begin
              r_phase <= r_phase + 2'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ab    <= AB_00;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign A          = r_ab[1];
  assign B          = r_ab[0];
  assign pos        = r_pos;
  assign busy       = r_busy;
  assign step_ready = r_ready;
`ifdef QUAD_STEP_GEN_INDEX_EN
  assign idx        = r_idx;
`endif

endmodule

// File: tb/tb_quad_step_gen.sv
// tb_quad_step_gen: self-checking bench for quad_step_gen.
// Table-driven steps with hand-derived positions, randomized steps against a
// sequence/modular-arithmetic reference model, and multi-cycle corner cases.
module tb_quad_step_gen;

  localparam int MAXV = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_valid = 1'b0;
  logic        step_dir = 1'b0;
  logic [15:0] dwell = 16'd0;
  logic        step_ready;
  logic        A;
  logic        B;
  logic [7:0]  pos;
  logic        busy;
`ifdef QUAD_STEP_GEN_INDEX_EN
  logic        idx;
`endif

  int errors = 0;
  int checks = 0;
  int m_pos  = 0;

  // Expected {A,B} after n transitions of a step, per direction
  logic [1:0] seq_cw  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] seq_ccw [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 clk = ~clk;

  quad_step_gen #(
    .DWELL_W (16),
    .POS_W   (8),
    .MAX     (8'd120)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .dwell      (dwell),
    .A          (A),
    .B          (B),
    .pos        (pos),
    .busy       (busy)
`ifdef QUAD_STEP_GEN_INDEX_EN
    ,
    .idx        (idx)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_next_pos(input int p, input bit dir_cw);
    return dir_cw ? (p + 1) % (MAXV + 1) : (p + MAXV) % (MAXV + 1);
  endfunction

  // The next rising edge must be the accept edge. Checks every cycle of the
  // step against the model; optionally changes dwell after edge mid_k.
  task automatic run_step(input bit dir_cw, input int de, input bit drop_valid,
                          input int mid_k, input logic [15:0] mid_dwell, input string tag);
    int         old_pos;
    int         new_pos;
    bit         wrap;
    bit         last;
    int         n;
    logic [1:0] exp_ab;
    old_pos = m_pos;
    new_pos = model_next_pos(old_pos, dir_cw);
    wrap    = dir_cw ? (old_pos == MAXV) : (old_pos == 0);
    @(posedge clk); #1;
    chk({tag, " accept busy"},  busy, 1);
    chk({tag, " accept ready"}, step_ready, 0);
    chk({tag, " accept ab"},    {A, B}, 0);
`ifdef QUAD_STEP_GEN_INDEX_EN
    chk({tag, " accept idx"},   idx, 0);
`endif
    if (drop_valid) step_valid = 1'b0;
    for (int k = 1; k <= 4 * de; k++) begin
      @(posedge clk); #1;
      n      = k / de;
      exp_ab = dir_cw ? seq_cw[n % 4] : seq_ccw[n % 4];
      last   = (k == 4 * de);
      chk({tag, " ab"},    {A, B}, exp_ab);
      chk({tag, " busy"},  busy, !last);
      chk({tag, " ready"}, step_ready, last);
      chk({tag, " pos"},   pos, last ? new_pos : old_pos);
`ifdef QUAD_STEP_GEN_INDEX_EN
      chk({tag, " idx"},   idx, last ? wrap : 1'b0);
`endif
      if (k == mid_k) dwell = mid_dwell;
    end
    m_pos = new_pos;
  endtask

  typedef struct {
    bit          dir_cw;
    logic [15:0] dw;
    int          exp_pos;
    bit          exp_idx;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int acc;
    int last_cyc;
    int bad;
    int cyc;
    bit prev_busy;
    int de;

    tbl[0] = '{1'b0, 16'd2, 0,   1'b0};  // 1 -> 0
    tbl[1] = '{1'b0, 16'd3, 120, 1'b1};  // 0 -> 120 wraps
    tbl[2] = '{1'b1, 16'd1, 0,   1'b1};  // 120 -> 0 wraps
    tbl[3] = '{1'b1, 16'd0, 1,   1'b0};  // dwell 0 acts as 1
    tbl[4] = '{1'b1, 16'd4, 2,   1'b0};
    tbl[5] = '{1'b0, 16'd0, 1,   1'b0};

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("reset A",    A, 0);
    chk("reset B",    B, 0);
    chk("reset pos",  pos, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", step_ready, 1);

    // CW step, dwell 3: changes every 3 clocks, pos 0 -> 1
    step_dir = 1'b1; dwell = 16'd3; step_valid = 1'b1;
    run_step(1'b1, 3, 1'b1, 0, 16'd0, "cw_d3");

    // Table-driven steps
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step_dir = tbl[i].dir_cw; dwell = tbl[i].dw; step_valid = 1'b1;
      de = (tbl[i].dw == 16'd0) ? 1 : int'(tbl[i].dw);
      run_step(tbl[i].dir_cw, de, 1'b1, 0, 16'd0, "tbl");
      chk("tbl pos", pos, tbl[i].exp_pos);
`ifdef QUAD_STEP_GEN_INDEX_EN
      chk("tbl idx", idx, tbl[i].exp_idx);
`endif
    end

    // Valid held through RUN, dwell 2 -> 9 mid-step; next step uses 9
    @(negedge clk);
    step_dir = 1'b1; dwell = 16'd2; step_valid = 1'b1;
    run_step(1'b1, 2, 1'b0, 3, 16'd9, "held_a");
    run_step(1'b1, 9, 1'b1, 0, 16'd0, "held_b");

    // Randomized steps against the reference model
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      step_dir = 1'($urandom_range(0, 1));
      dwell    = 16'($urandom_range(0, 4));
      step_valid = 1'b1;
      de = (dwell == 16'd0) ? 1 : int'(dwell);
      run_step(step_dir, de, 1'b1, 0, 16'd0, "rnd");
    end

    // Make pos nonzero before the reset test
    if (m_pos == 0) begin
      @(negedge clk);
      step_dir = 1'b1; dwell = 16'd1; step_valid = 1'b1;
      run_step(1'b1, 1, 1'b1, 0, 16'd0, "pre_rst");
    end

    // Async reset after the 2nd transition of a CW step
    @(negedge clk);
    step_dir = 1'b1; dwell = 16'd4; step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid pre ab",  {A, B}, 2'b11);
    chk("rst_mid pre pos", pos, m_pos);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid A",    A, 0);
    chk("rst_mid B",    B, 0);
    chk("rst_mid pos",  pos, 0);
    chk("rst_mid busy", busy, 0);
    m_pos = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid ready", step_ready, 1);
    chk("rst_mid idle ab", {A, B}, 0);
    step_dir = 1'b0; dwell = 16'd2; step_valid = 1'b1;
    run_step(1'b0, 2, 1'b1, 0, 16'd0, "post_rst");

    // Return to 0 (wraps 120 -> 0)
    @(negedge clk);
    step_dir = 1'b1; dwell = 16'd1; step_valid = 1'b1;
    run_step(1'b1, 1, 1'b1, 0, 16'd0, "to_zero");

    // 121 back-to-back CW steps with dwell 1, valid held
    @(negedge clk);
    step_dir = 1'b1; dwell = 16'd1; step_valid = 1'b1;
    acc = 0; last_cyc = 0; bad = 0; cyc = 0; prev_busy = busy;
    while (acc < 121 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (busy && !prev_busy) begin
        if (acc > 0 && (cyc - last_cyc) != 5) bad++;
        last_cyc = cyc;
        acc++;
        if (acc == 121) begin
          chk("b2b pos before last", pos, 120);
          step_valid = 1'b0;
        end
      end
      prev_busy = busy;
    end
    chk("b2b accepts", acc, 121);
    chk("b2b spacing errors", bad, 0);
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b busy done", busy, 0);
    chk("b2b final pos", pos, 0);
    m_pos = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
